aes_key_sched: RTL
==================

AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 SHALL have parameter NR, default 10, giving the number of expansion rounds (AES-128).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, a one-cycle request to expand key_in.
REQ-005 SHALL have port key_in, input, 128, the cipher key, big-endian (w0 = bits 127:96).
REQ-006 SHALL have port kld_o, output, 1, the round-constant generator load strobe.
REQ-007 SHALL have port knxt_o, output, 1, the round-constant generator advance strobe.
REQ-008 SHALL have port rcon_i, input, 32, the current round constant; byte in 31:24, other bytes zero.
REQ-009 SHALL have port busy, output, 1, high while expansion is in progress.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when all round keys are valid.
REQ-011 SHALL have port rd_addr, input, 4, the round-key index 0..NR.
REQ-012 SHALL have port rd_key, output, 128, the registered round key for rd_addr.

Function
REQ-013 SHALL implement a three-state FSM: IDLE -> LOAD -> EXPAND -> IDLE.
REQ-014 In IDLE with start=1 (cycle T): kld_o SHALL be 1 combinationally; key_in SHALL be written to rk[0] and the working word registers; next state SHALL be LOAD.
REQ-015 LOAD SHALL last one cycle so that rcon_i = 32'h01000000 is valid; round counter SHALL be set to 1; next state SHALL be EXPAND.
REQ-016 Each EXPAND cycle SHALL compute the next key as follows.
- t = SubWord(RotWord(w3)) ^ rcon_i
- w4 = w0^t, w5 = w4^w1, w6 = w5^w2, w7 = w6^w3
- Write rk[cnt], update the working words, assert knxt_o, increment cnt.
REQ-017 EXPAND SHALL run exactly NR cycles, so rk[10] is written at the end of cycle T+11.
REQ-018 done SHALL pulse for one cycle in cycle T+12, the first cycle back in IDLE.
REQ-019 busy SHALL be 1 in LOAD and EXPAND and 0 otherwise.
REQ-020 kld_o SHALL only be asserted in IDLE, and knxt_o only in EXPAND; they SHALL never be asserted together.
REQ-021 start while busy SHALL be ignored, with no restart and no change to kld_o.
REQ-022 rd_key SHALL equal rk[rd_addr] one cycle after rd_addr is presented.
REQ-023 rd_addr > NR SHALL return 128'h0.
REQ-024 Reading an index while its entry is being written SHALL return the pre-write value.
REQ-025 Round-key storage SHALL persist after done until the next accepted start.
REQ-026 A new start in IDLE SHALL overwrite rk[0..NR] progressively; reads during this rewrite return whichever value is currently stored.
REQ-027 All XOR and byte operations SHALL be 32-bit word-wise, with no carries.
REQ-028 SubWord SHALL apply the FIPS-197 S-box to each of the 4 bytes in parallel (4 instances).

Reset
REQ-029 rst_n low SHALL asynchronously force the following state, regardless of the current cycle.
- FSM = IDLE, cnt = 0, working words = 0, rk[0..NR] = 0
- busy = 0, done = 0, rd_key = 0, kld_o = 0, knxt_o = 0
REQ-030 Reset asserted mid-EXPAND SHALL abort the expansion with no done pulse; after release the block SHALL accept start normally.

Structure
REQ-031 A shared AES package SHALL hold AES_NR = 10, AES_NK = 4, the typedefs aes_word_t (32 bits) and aes_block_t (128 bits), and the FSM state enum.
REQ-032 One sub-module, aes_sbox (8-bit combinational FIPS-197 S-box), SHALL be instantiated 4 times.
REQ-033 The round-constant generator SHALL remain external, connected through kld_o, knxt_o and rcon_i.

Verification
REQ-034 The bench SHALL pair the block with the real round-constant generator and cover these directed scenarios.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start -> rk[1] = a0fafe1788542cb123a339392a6c7605, rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6, done at T+12.
- All-zero key -> rk[1] = 62636363626363636263636362636363, rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- start pulsed during EXPAND -> ignored; the rk[10] result is unchanged; kld_o stays 0.
- rst_n low at round 5 -> all outputs 0 immediately; no done; the next start completes correctly.
- rd_addr = 15 -> rd_key = 0; rd_addr = 0 after load -> key_in with 1-cycle latency.
- Protocol check -> kld_o and knxt_o never both 1; exactly 10 knxt_o pulses per expansion.

Source files
------------

// File: rtl/aes_key_sched_pkg.sv
// Shared AES definitions for the key-schedule block.
// Holds the AES-128 round/key-word counts, the word and block typedefs,
// the key-schedule FSM state encoding and the RotWord helper.
package aes_key_sched_pkg;

    localparam int AES_NR = 10;   // expansion rounds for AES-128
    localparam int AES_NK = 4;    // key length in 32-bit words

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2
    } ks_state_e;

    // Cyclic left rotate by one byte: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Host-side bus of the key-schedule block.
//   start   : one-cycle request to expand key_in
//   key_in  : 128-bit cipher key, w0 in bits 127:96
//   busy    : expansion in progress
//   done    : one-cycle pulse when all round keys are stored
//   rd_addr : round-key index to read
//   rd_key  : registered round key for rd_addr (one-cycle latency)
// master = host side, slave = key-schedule side.
interface aes_key_sched_if;
    import aes_key_sched_pkg::*;

    logic       start;
    aes_block_t key_in;
    logic       busy;
    logic       done;
    logic [3:0] rd_addr;
    aes_block_t rd_key;

    modport master (output start, key_in, rd_addr, input busy, done, rd_key);
    modport slave  (input start, key_in, rd_addr, output busy, done, rd_key);

endinterface

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box, purely combinational, one byte in, one byte out.
//   in_byte  : byte to substitute
//   out_byte : S-box image of in_byte
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0x00 sits in the most significant byte, so the bit offset of
    // entry a is (255 - a) * 8, i.e. {~a, 3'b000}.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_idx;

    assign bit_idx  = {~in_byte, 3'b000};
    assign out_byte = SBOX_TABLE[bit_idx +: 8];

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key expansion with an addressable round-key store.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : host bus (start/key_in/busy/done/rd_addr/rd_key)
//   kld_o      : load strobe for the external round-constant generator
//   knxt_o     : advance strobe for the external round-constant generator
//   rcon_i     : current round constant, byte in bits 31:24
// One round key is produced per EXPAND cycle; rk[0..NR] persist until the
// next accepted start.
module aes_key_sched
    import aes_key_sched_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_key_sched_if.slave        bus,
    output logic                  kld_o,
    output logic                  knxt_o,
    input  aes_word_t             rcon_i
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ks_state_e  state;
    ks_state_e  state_nxt;
    logic [3:0] cnt;
    aes_word_t  w0, w1, w2, w3;
    aes_block_t rk [NR+1];
    logic       done_q;
    aes_block_t rd_q;
    aes_block_t rd_nxt;

    aes_word_t  rot;
    aes_word_t  sub;
    aes_word_t  t;
    aes_word_t  w4, w5, w6, w7;

    // Round function: t = SubWord(RotWord(w3)) ^ rcon, then chained XORs.
    assign rot = rot_word(w3);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot[8*i +: 8]),
            .out_byte (sub[8*i +: 8])
        );
    end

    assign t  = sub ^ rcon_i;
    assign w4 = w0 ^ t;
    assign w5 = w4 ^ w1;
    assign w6 = w5 ^ w2;
    assign w7 = w6 ^ w3;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.start) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_EXPAND;
            ST_EXPAND: if (cnt == LAST_ROUND) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; kld_o is gated by rst_n so it is low for the whole reset.
    always_comb begin
        kld_o    = rst_n && (state == ST_IDLE) && bus.start;
        knxt_o   = (state == ST_EXPAND);
        bus.busy = (state != ST_IDLE);
    end

    // Datapath: working words, round counter and round-key store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            w0  <= '0;
            w1  <= '0;
            w2  <= '0;
            w3  <= '0;
            for (int i = 0; i <= NR; i++) begin
                rk[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        rk[0]            <= bus.key_in;
                        {w0, w1, w2, w3} <= bus.key_in;
                    end
                end
                ST_LOAD: begin
                    cnt <= 4'd1;
                end
                ST_EXPAND: begin
                    rk[cnt]          <= {w4, w5, w6, w7};
                    {w0, w1, w2, w3} <= {w4, w5, w6, w7};
                    cnt              <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Read port: out-of-range indices decode to zero.
    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i <= NR; i++) begin
            if (bus.rd_addr == 4'(i)) rd_nxt = rk[i];
        end
    end

    // Registered read data and the done pulse issued on return to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            done_q <= 1'b0;
        end else begin
            rd_q   <= rd_nxt;
            done_q <= (state == ST_EXPAND) && (cnt == LAST_ROUND);
        end
    end

    assign bus.rd_key = rd_q;
    assign bus.done   = done_q;

endmodule
